// File: rtl/dbgu32_host.sv
// Host-side initiator for the 32-bit UART debug protocol: serialises one command into
// request bytes, collects the target's reply and returns it as a single response.
module dbgu32_host #(
  parameter int unsigned TIMEOUT_CYCLES = 1200000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_op,
  input  logic [31:0] cmd_arg,
  output logic        rsp_valid,
  output logic [1:0]  rsp_status,
  output logic [31:0] rsp_data,
  output logic        busy,
  input  logic        cts,
  output logic        utx_write,
  output logic [7:0]  utx_data,
  input  logic        utx_finished,
  input  logic        urx_ready,
  input  logic [7:0]  urx_data
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_CTS,
    SEND,
    SEND_WAIT,
    RECV
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    op_q, op_d;
  logic [31:0]   arg_q, arg_d;
  logic [2:0]    tx_cnt_q, tx_cnt_d;
  logic [2:0]    rx_idx_q, rx_idx_d;
  logic [31:0]   rx_buf_q, rx_buf_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [1:0]    rsp_status_q, rsp_status_d;
  logic [31:0]   rsp_data_q, rsp_data_d;
  logic          utx_write_q, utx_write_d;
  logic [7:0]    utx_data_q, utx_data_d;

  logic [2:0]    req_len;
  logic [2:0]    rx_len;
  logic [1:0]    pay_idx;

  // Request length includes the opcode byte; unknown opcodes send just the opcode.
  always_comb begin
    req_len = 3'd1;
    rx_len  = 3'd1;
    case (op_q)
      8'h01, 8'h04: req_len = 3'd5;
      8'h20, 8'h22: req_len = 3'd2;
      default:      req_len = 3'd1;
    endcase
    case (op_q)
      8'h03, 8'h05: rx_len = 3'd4;
      default:      rx_len = 3'd1;
    endcase
  end

  assign pay_idx = tx_cnt_q[1:0] - 2'd1;

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    arg_d        = arg_q;
    tx_cnt_d     = tx_cnt_q;
    rx_idx_d     = rx_idx_q;
    rx_buf_d     = rx_buf_q;
    tmo_d        = tmo_q;
    rsp_valid_d  = 1'b0;
    rsp_status_d = rsp_status_q;
    rsp_data_d   = rsp_data_q;
    utx_write_d  = 1'b0;
    utx_data_d   = utx_data_q;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d     = cmd_op;
          arg_d    = cmd_arg;
          tx_cnt_d = 3'd0;
          rx_idx_d = 3'd0;
          rx_buf_d = 32'h0;
          tmo_d    = '0;
          state_d  = WAIT_CTS;
        end
      end
      WAIT_CTS: begin
        if (!cts) begin
          utx_write_d = 1'b1;
          utx_data_d  = op_q;
          tx_cnt_d    = 3'd1;
          state_d     = SEND;
        end
      end
      SEND: begin
        state_d = SEND_WAIT;
      end
      SEND_WAIT: begin
        if (utx_finished) begin
          if (tx_cnt_q < req_len) begin
            utx_write_d = 1'b1;
            utx_data_d  = arg_q[{pay_idx, 3'b000} +: 8];
            tx_cnt_d    = tx_cnt_q + 3'd1;
            state_d     = SEND;
          end else begin
            tmo_d   = '0;
            state_d = RECV;
          end
        end
      end
      RECV: begin
        // A complete reply is reported one edge after its last byte was stored.
        if (rx_idx_q == rx_len) begin
          rsp_valid_d = 1'b1;
          rsp_data_d  = rx_buf_q;
          if (rx_len == 3'd4)              rsp_status_d = 2'b00;
          else if (rx_buf_q[7:0] == 8'h01) rsp_status_d = 2'b00;
          else if (rx_buf_q[7:0] == 8'h02) rsp_status_d = 2'b01;
          else                             rsp_status_d = 2'b11;
          state_d = IDLE;
        end else if (urx_ready) begin
          rx_buf_d[{rx_idx_q[1:0], 3'b000} +: 8] = urx_data;
          rx_idx_d = rx_idx_q + 3'd1;
          tmo_d    = '0;
        end else if (tmo_q == TMO_LAST) begin
          rsp_valid_d  = 1'b1;
          rsp_status_d = 2'b10;
          rsp_data_d   = rx_buf_q;
          state_d      = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= 8'h0;
      arg_q        <= 32'h0;
      tx_cnt_q     <= 3'd0;
      rx_idx_q     <= 3'd0;
      rx_buf_q     <= 32'h0;
      tmo_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_status_q <= 2'b00;
      rsp_data_q   <= 32'h0;
      utx_write_q  <= 1'b0;
      utx_data_q   <= 8'h0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      arg_q        <= arg_d;
      tx_cnt_q     <= tx_cnt_d;
      rx_idx_q     <= rx_idx_d;
      rx_buf_q     <= rx_buf_d;
      tmo_q        <= tmo_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_status_q <= rsp_status_d;
      rsp_data_q   <= rsp_data_d;
      utx_write_q  <= utx_write_d;
      utx_data_q   <= utx_data_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE) && !reset;
  assign busy       = (state_q != IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = rsp_status_q;
  assign rsp_data   = rsp_data_q;
  assign utx_write  = utx_write_q;
  assign utx_data   = utx_data_q;

endmodule

// File: tb/tb_dbgu32_host.sv
// Directed bench for dbgu32_host with a simple UART model that finishes each byte
// ten cycles after its write pulse.
module tb_dbgu32_host;

  localparam int unsigned TMO = 100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_op = 8'h0;
  logic [31:0] cmd_arg = 32'h0;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_data;
  logic        busy;
  logic        cts = 1'b0;
  logic        utx_write;
  logic [7:0]  utx_data;
  logic        utx_finished = 1'b0;
  logic        urx_ready = 1'b0;
  logic [7:0]  urx_data = 8'h0;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          rsp_count = 0;
  int          fin_cnt = 0;
  logic [7:0]  tx_q[$];

  dbgu32_host #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_arg      (cmd_arg),
    .rsp_valid    (rsp_valid),
    .rsp_status   (rsp_status),
    .rsp_data     (rsp_data),
    .busy         (busy),
    .cts          (cts),
    .utx_write    (utx_write),
    .utx_data     (utx_data),
    .utx_finished (utx_finished),
    .urx_ready    (urx_ready),
    .urx_data     (urx_data)
  );

  always #5 clk = ~clk;

  // Record every transmitted byte and every response pulse
  always @(posedge clk) begin
    if (utx_write) tx_q.push_back(utx_data);
    if (rsp_valid) rsp_count++;
  end

  // UART transmitter model: utx_finished pulses ten cycles after a write
  always @(negedge clk) begin
    utx_finished = 1'b0;
    if (reset) begin
      fin_cnt = 0;
    end else begin
      if (fin_cnt > 0) begin
        fin_cnt--;
        if (fin_cnt == 0) utx_finished = 1'b1;
      end
      if (utx_write) fin_cnt = 10;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] op, input logic [31:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic injectByte(input logic [7:0] b);
    urx_ready = 1'b1;
    urx_data  = b;
    tick();
    urx_ready = 1'b0;
  endtask

  task automatic waitTx(input string tag, input int n, input int settle);
    for (int i = 0; i < 500 && tx_q.size() < n; i++) tick();
    checkOutput(tag, tx_q.size(), n);
    repeat (settle) tick();
  endtask

  task automatic waitRsp(input string tag, input logic [1:0] status, input logic [31:0] data);
    int k;
    k = 0;
    while (!rsp_valid && k < 500) begin
      tick();
      k++;
    end
    checkOutput({tag, "_valid"}, rsp_valid, 1);
    checkOutput({tag, "_status"}, rsp_status, status);
    checkOutput({tag, "_data"}, rsp_data, data);
    checkOutput({tag, "_cmd_ready"}, cmd_ready, 1);
    tick();
    checkOutput({tag, "_pulse"}, rsp_valid, 0);
  endtask

  initial begin
    int base;
    int rc;
    int m;
    logic [7:0] exp1 [5];

    $display("[TB] reset state");
    repeat (3) tick();
    checkOutput("rst_cmd_ready_low", cmd_ready, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_utx_write", utx_write, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    reset = 1'b0;
    #1;
    checkOutput("rst_cmd_ready_high", cmd_ready, 1);
    checkOutput("rst_rsp_status", rsp_status, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_utx_data", utx_data, 0);

    $display("[TB] ADR_SET");
    exp1 = '{8'h01, 8'h78, 8'h56, 8'h34, 8'h12};
    base = tx_q.size();
    applyStimulus(8'h01, 32'h12345678);
    checkOutput("t1_busy", busy, 1);
    waitTx("t1_txn", base + 5, 15);
    for (int i = 0; i < 5; i++) checkOutput($sformatf("t1_byte%0d", i), tx_q[base + i], exp1[i]);
    injectByte(8'h01);
    waitRsp("t1", 2'b00, 32'h00000001);

    $display("[TB] MEM_RD");
    base = tx_q.size();
    applyStimulus(8'h05, 32'hDEADBEEF);
    waitTx("t2_txn", base + 1, 15);
    checkOutput("t2_byte0", tx_q[base], 8'h05);
    injectByte(8'h04);
    injectByte(8'h03);
    injectByte(8'h02);
    injectByte(8'h01);
    waitRsp("t2", 2'b00, 32'h01020304);
    checkOutput("t2_txn_after", tx_q.size(), base + 1);

    $display("[TB] unknown opcode NAK and protocol error");
    base = tx_q.size();
    applyStimulus(8'h7F, 32'hFFFFFFFF);
    waitTx("t3_txn", base + 1, 15);
    checkOutput("t3_byte0", tx_q[base], 8'h7F);
    injectByte(8'h02);
    waitRsp("t3_nak", 2'b01, 32'h00000002);
    base = tx_q.size();
    applyStimulus(8'h7F, 32'h0);
    waitTx("t3b_txn", base + 1, 15);
    injectByte(8'h55);
    waitRsp("t3_proto", 2'b11, 32'h00000055);

    $display("[TB] flow control");
    cts = 1'b1;
    base = tx_q.size();
    applyStimulus(8'h21, 32'h0);
    repeat (50) tick();
    checkOutput("t4_no_tx", tx_q.size(), base);
    checkOutput("t4_busy", busy, 1);
    cts = 1'b0;
    tick();
    checkOutput("t4_write", utx_write, 1);
    checkOutput("t4_data", utx_data, 8'h21);
    tick();
    checkOutput("t4_write_one", utx_write, 0);
    repeat (15) tick();
    injectByte(8'h01);
    waitRsp("t4", 2'b00, 32'h00000001);

    $display("[TB] reply timeout");
    base = tx_q.size();
    applyStimulus(8'h03, 32'h0);
    waitTx("t5_txn", base + 1, 15);
    injectByte(8'hAA);
    injectByte(8'hBB);
    m = 0;
    while (!rsp_valid && m < 500) begin
      tick();
      m++;
    end
    checkOutput("t5_latency", m, 100);
    checkOutput("t5_status", rsp_status, 2'b10);
    checkOutput("t5_data", rsp_data, 32'h0000BBAA);
    checkOutput("t5_cmd_ready", cmd_ready, 1);

    $display("[TB] reset mid-transaction");
    tick();
    base = tx_q.size();
    applyStimulus(8'h04, 32'hA1B2C3D4);
    waitTx("t6_txn", base + 3, 2);
    checkOutput("t6_byte2", tx_q[base + 2], 8'hC3);
    reset = 1'b1;
    #1;
    checkOutput("t6_cmd_ready_low", cmd_ready, 0);
    tick();
    reset = 1'b0;
    #1;
    checkOutput("t6_utx_write", utx_write, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_cmd_ready", cmd_ready, 1);
    checkOutput("t6_rsp_data", rsp_data, 0);
    checkOutput("t6_rsp_status", rsp_status, 0);
    rc = rsp_count;
    injectByte(8'h01);
    repeat (30) tick();
    checkOutput("t6_no_rsp", rsp_count, rc);
    checkOutput("t6_idle", busy, 0);
    checkOutput("t6_no_more_tx", tx_q.size(), base + 3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
